// File: rtl/common_types_pkg.sv
// Shared types for the execute-stage blocks: RISC-V M-extension divide
// funct3 encodings plus small decode helpers used by divider_ctrl.
package common_types_pkg;

    typedef enum logic [2:0] {
        DIV_OP_DIV  = 3'b100,
        DIV_OP_DIVU = 3'b101,
        DIV_OP_REM  = 3'b110,
        DIV_OP_REMU = 3'b111
    } div_op_t;

    // Signed variants are DIV and REM (funct3 bit 0 clear).
    function automatic logic div_op_is_signed(input logic [2:0] op);
        logic res;
        case (div_op_t'(op))
            DIV_OP_DIV, DIV_OP_REM: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    // Remainder variants are REM and REMU (funct3 bit 1 set).
    function automatic logic div_op_is_rem(input logic [2:0] op);
        logic res;
        case (div_op_t'(op))
            DIV_OP_REM, DIV_OP_REMU: res = 1'b1;
            default:                 res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Handshake between divider_ctrl and the shared long-division divider.
// The divider side uses the div modport, the sequencer the mirrored ctrl one.
interface divider_if;
    logic        en;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        ready;
    logic        div_by_zero;
    logic        overflow;

    modport div  (input  en, is_signed, a, b,
                  output q, r, ready, div_by_zero, overflow);
    modport ctrl (output en, is_signed, a, b,
                  input  q, r, ready, div_by_zero, overflow);
endinterface

// File: rtl/div_result_cache.sv
// Single-entry result store for divider_ctrl: remembers operands, signedness,
// quotient and remainder of the last completed divide and flags a tag match.
// Only built when DIV_RESULT_CACHE_EN is defined.
`ifdef DIV_RESULT_CACHE_EN
module div_result_cache (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_en,
    input  logic [31:0] wr_a,
    input  logic [31:0] wr_b,
    input  logic        wr_signed,
    input  logic [31:0] wr_q,
    input  logic [31:0] wr_r,
    input  logic [31:0] lk_a,
    input  logic [31:0] lk_b,
    input  logic        lk_signed,
    output logic        hit,
    output logic [31:0] hit_q,
    output logic [31:0] hit_r
);
    logic        valid_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        signed_r;
    logic [31:0] q_r;
    logic [31:0] r_r;

    // Capture the entry of each completed operation; reset invalidates it.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid_r  <= 1'b0;
            a_r      <= 32'h0;
            b_r      <= 32'h0;
            signed_r <= 1'b0;
            q_r      <= 32'h0;
            r_r      <= 32'h0;
        end else if (wr_en) begin
            valid_r  <= 1'b1;
            a_r      <= wr_a;
            b_r      <= wr_b;
            signed_r <= wr_signed;
            q_r      <= wr_q;
            r_r      <= wr_r;
        end
    end

    assign hit   = valid_r && (a_r == lk_a) && (b_r == lk_b) && (signed_r == lk_signed);
    assign hit_q = q_r;
    assign hit_r = r_r;
endmodule
`endif

// File: rtl/divider_ctrl.sv
// divider_ctrl: sequences DIV/DIVU/REM/REMU requests onto the shared divider,
// holds operands stable for the whole operation, returns the quotient or
// remainder with a one-cycle done pulse and absorbs pipeline flushes.
// Optional result reuse for repeated operands: define DIV_RESULT_CACHE_EN.
module divider_ctrl
    import common_types_pkg::*;
(
    input  logic          clk,
    input  logic          nrst,
    input  logic          req,
    input  logic [2:0]    op,
    input  logic [31:0]   a,
    input  logic [31:0]   b,
    input  logic          flush,
    output logic          stall,
    output logic          done,
    output logic [31:0]   result,
    output logic          busy,
    divider_if.ctrl       dif
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESP} state_t;

    state_t      state_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        signed_r;
    logic        sel_rem_r;
    logic [31:0] result_r;
    logic        en_r;
    logic        busy_r;

    logic        acc_signed_s;
    logic        acc_rem_s;
    logic        hit_s;
    logic [31:0] hit_q_s;
    logic [31:0] hit_r_s;

    assign acc_signed_s = div_op_is_signed(op);
    assign acc_rem_s    = div_op_is_rem(op);

`ifdef DIV_RESULT_CACHE_EN
    logic [31:0] q_r;
    logic [31:0] r_r;
    logic        cache_wr_s;

    // Only a response that actually reaches the pipeline refreshes the entry.
    assign cache_wr_s = (state_r == RESP) && !flush;

    div_result_cache u_cache (
        .clk       (clk),
        .nrst      (nrst),
        .wr_en     (cache_wr_s),
        .wr_a      (a_r),
        .wr_b      (b_r),
        .wr_signed (signed_r),
        .wr_q      (q_r),
        .wr_r      (r_r),
        .lk_a      (a),
        .lk_b      (b),
        .lk_signed (acc_signed_s),
        .hit       (hit_s),
        .hit_q     (hit_q_s),
        .hit_r     (hit_r_s)
    );

    // Keep both quotient and remainder of the current op for the cache entry.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            q_r <= 32'h0;
            r_r <= 32'h0;
        end else if ((state_r == IDLE) && req && !flush && hit_s) begin
            q_r <= hit_q_s;
            r_r <= hit_r_s;
        end else if ((state_r == WAIT) && dif.ready) begin
            q_r <= dif.q;
            r_r <= dif.r;
        end
    end
`else
    assign hit_s   = 1'b0;
    assign hit_q_s = 32'h0;
    assign hit_r_s = 32'h0;
`endif

    // Main sequencer: accept, issue, wait/drain, respond; en and busy registered.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r   <= IDLE;
            a_r       <= 32'h0;
            b_r       <= 32'h0;
            signed_r  <= 1'b0;
            sel_rem_r <= 1'b0;
            result_r  <= 32'h0;
            en_r      <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req && !flush) begin
                        a_r       <= a;
                        b_r       <= b;
                        signed_r  <= acc_signed_s;
                        sel_rem_r <= acc_rem_s;
                        busy_r    <= 1'b1;
                        if (hit_s) begin
                            result_r <= acc_rem_s ? hit_r_s : hit_q_s;
                            state_r  <= RESP;
                        end else begin
                            en_r    <= 1'b1;
                            state_r <= ISSUE;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        // The divider cannot be aborted; finish it silently.
                        if (dif.ready) begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else if (dif.ready) begin
                        result_r <= sel_rem_r ? dif.r : dif.q;
                        state_r  <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DRAIN: begin
                    if (dif.ready) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                RESP: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign dif.en        = en_r;
    assign dif.a         = a_r;
    assign dif.b         = b_r;
    assign dif.is_signed = signed_r;

    assign done   = (state_r == RESP) && !flush;
    assign stall  = req && !done;
    assign busy   = busy_r;
    assign result = result_r;
endmodule

// File: doc/divider_ctrl.md
# divider_ctrl

Sequencer that sits between the execute stage and the shared long-division `divider`. It decodes RISC-V M-extension DIV/DIVU/REM/REMU requests and latches the operands. It issues a single-cycle start to the divider, holds the operands stable for the whole operation, and returns the selected quotient or remainder with a one-cycle `done` pulse. It also handles pipeline flushes mid-division and, optionally, reuses the previous result for back-to-back DIV/REM on identical operands.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `nrst`  in  1  synchronous, active-low reset.
- `req`  in  1  execute stage has a divide op; held high until `done`.
- `op`  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`, `b`  in  32 each  dividend and divisor (rs1, rs2).
- `flush`  in  1  kill the in-flight op; no `done` is produced for it.
- `stall`  out  1  `req && !done`; holds the pipeline.
- `done`  out  1  one-cycle pulse; `result` is valid only in this cycle.
- `result`  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).
- `busy`  out  1  state != IDLE.
- `divider_if`  ctrl modport: drives `en`, `is_signed`, `a`, `b`; samples `q`, `r`, `ready`. `div_by_zero` and `overflow` are ignored, because the divider already returns RISC-V-defined values.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, RESP.
- **IDLE**
  - Accept when `req && !flush`.
  - Latch `a`, `b`, `is_signed = !op[0]`, `sel_rem = op[1]`.
  - Go to ISSUE, or to RESP on a cache hit.
  - Every `req` seen in IDLE is a new op.
- **ISSUE**
  - `en = 1` for exactly this cycle.
  - Next state: WAIT, or DRAIN if `flush`.
- **WAIT**
  - On `ready`: register `result = sel_rem ? r : q` and go to RESP.
  - `flush` (including the same cycle as `ready`) goes to DRAIN, or straight to IDLE if `ready` is also high. The result is discarded.
- **DRAIN**
  - The divider cannot be aborted, so stay here until `ready`, then go to IDLE.
  - `req` is not accepted while in DRAIN.
- **RESP**
  - `done = !flush`, then go to IDLE unconditionally.
- `divider_if.a`, `divider_if.b` and `divider_if.is_signed` are driven from the latched registers in every state.
  - They must not change between ISSUE and the `ready` cycle; the divider uses them for precheck and sign correction.
- **Divide by zero:** the divider returns quotient 0xFFFFFFFF and remainder = a. The controller passes these through unmodified.
- **Signed overflow (0x80000000 / −1):** quotient 0x80000000, remainder 0, passed through unmodified.
- **Reset values:** state IDLE; `done`, `stall`, `busy`, `en` = 0; `result` = 0; cache valid = 0.
- **Reset mid-operation:** the divider shares `nrst`, so both blocks return to idle in the same cycle. No `done` is produced.

## Timing
Request accepted in cycle T (IDLE, `req` high):

| Case | `en` | divider PRECHECK | divider DIVIDE | divider DONE / `ready` | `done` (RESP) |
|---|---|---|---|---|---|
| Normal division | T+1 | T+2 | T+3 to T+34 | T+35 | T+36 |
| Divide by zero or signed overflow | T+1 | T+2 (`ready` here) | — | — | T+3 |
| Cache hit | — | — | — | — | T+1 |

- The earliest next accept is the cycle after `done`.
- After a flush, the next accept is the cycle after the divider's `ready`.

## Configuration
- **`DIV_RESULT_CACHE_EN` defined:**
  - Stores a, b, is_signed, q and r of the last completed (non-flushed) operation, plus a valid bit.
  - A new request whose a, b and signedness all match hits the cache: RESP in T+1, result taken from the stored q or r, divider not started.
  - Flushed and drained operations never update the cache.
  - Flush does not invalidate the cache; reset does.
- **Not defined:** no cache logic. Every request goes through ISSUE/WAIT.

## Structure
- `div_op_t` (funct3 encodings DIV/DIVU/REM/REMU) goes in `common_types_pkg`.
- The state enum stays local to the module.
- One sub-module, `div_result_cache`, contains the storage and tag compare. It is instantiated only under `DIV_RESULT_CACHE_EN`.
- The `divider_if` interface gains a `ctrl` modport that mirrors the `div` modport.

## Test plan
- DIVU a=100, b=7 at T → `en` at T+1, `done` at T+36, result 14. REMU with the same operands → 2.
- DIV a=0xFFFFFFF9, b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. `stall` is high from T until `done`.
- DIVU a=0x1234, b=0 → `done` at T+3, result 0xFFFFFFFF. REMU with the same operands → 0x1234.
- DIV a=0x80000000, b=0xFFFFFFFF → `done` at T+3, result 0x80000000. REM with the same operands → 0.
- Flush at T+10 → no `done`, `busy` high until the divider `ready` at T+35, idle at T+36. A following DIVU 9/3 returns 3 with normal latency.
- Cache test: DIV 100/7, then REM 100/7.
  - With `DIV_RESULT_CACHE_EN`: REM `done` one cycle after accept, result 2, `en` never asserted.
  - Without the macro: 36-cycle latency.
  - With the macro, a flushed op with the same operands must not hit.
